// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with tear-free frame updates.
// Optional per-slot anode dimming is enabled by defining SEG7_BRIGHTNESS_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  localparam int unsigned IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [3:0]            bright,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [PRE_W-1:0]  prescaler, prescaler_n;
  logic [IDX_W-1:0]  digit_idx_n;
  logic [VAL_W-1:0]  shadow_val, shadow_val_n, pend_val, pend_val_n;
  logic [DIGITS-1:0] shadow_dp, shadow_dp_n, pend_dp, pend_dp_n;
  logic              pending, pending_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] an_n;
  logic [DIGITS-1:0] lz_mask;
  logic              zero_run;
  logic              slot_end_c;
  logic              frame_end_c;
  logic              lit_c;
  logic [3:0]        cur_nib;

  assign slot_end_c  = en && (prescaler == PRE_W'(SCAN_DIV - 1));
  assign frame_end_c = slot_end_c && (digit_idx == IDX_W'(DIGITS - 1));
  // Combinational so the pulse coincides with the wrap cycle itself.
  assign frame_done  = frame_end_c;

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] bright_q;
  logic [3:0] bright_eff;

  assign bright_eff = (prescaler == '0) ? bright : bright_q;
  assign lit_c = (32'(prescaler) < (((32'(bright_eff) + 32'd1) * SCAN_DIV) >> 4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= 4'hF;
    end else if (en && (prescaler == '0)) begin
      bright_q <= bright;
    end
  end
`else
  assign lit_c = 1'b1;
`endif

  // Digit i is a leading zero when it and all higher digits are zero; digit 0 never is.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow_val[i*4 +: 4] == 4'h0);
      if (i != 0) lz_mask[i] = zero_run;
    end
  end

  // Scan counters, pending/shadow data path and next output values.
  always_comb begin
    prescaler_n  = prescaler;
    digit_idx_n  = digit_idx;
    shadow_val_n = shadow_val;
    shadow_dp_n  = shadow_dp;
    pend_val_n   = pend_val;
    pend_dp_n    = pend_dp;
    pending_n    = pending;
    seg_n        = SEG_OFF;
    dp_n         = SEG_ACTIVE_LOW;
    an_n         = AN_OFF;
    cur_nib      = shadow_val[32'(digit_idx) * 4 +: 4];

    if (en) begin
      if (slot_end_c) begin
        prescaler_n = '0;
        digit_idx_n = (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        prescaler_n = prescaler + PRE_W'(1);
      end
      if (frame_end_c && pending) begin
        shadow_val_n = pend_val;
        shadow_dp_n  = pend_dp;
      end
      if (load) begin
        pend_val_n = value;
        pend_dp_n  = dp_in;
        pending_n  = 1'b1;
      end else if (frame_end_c) begin
        pending_n  = 1'b0;
      end

      seg_n = (blank_lz && lz_mask[digit_idx]) ? 7'h00 : hex7(cur_nib);
      seg_n = SEG_ACTIVE_LOW ? ~seg_n : seg_n;
      dp_n  = shadow_dp[digit_idx] ^ SEG_ACTIVE_LOW;
      if (lit_c) an_n = (DIGITS'(1) << digit_idx) ^ AN_OFF;
    end else if (load) begin
      shadow_val_n = value;
      shadow_dp_n  = dp_in;
      pending_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      digit_idx  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_OFF;
    end else begin
      prescaler  <= prescaler_n;
      digit_idx  <= digit_idx_n;
      shadow_val <= shadow_val_n;
      shadow_dp  <= shadow_dp_n;
      pend_val   <= pend_val_n;
      pend_dp    <= pend_dp_n;
      pending    <= pending_n;
      seg        <= seg_n;
      dp         <= dp_n;
      an         <= an_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4): directed scenarios then random
// traffic, compared against a frame-position reference model.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned FRAME    = DIGITS * SCAN_DIV;
  localparam logic [6:0] SEGTBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n, en, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]  bright = 4'hF;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model: position within the frame counted in enabled cycles.
  int          pos;
  logic [15:0] m_sh_v, m_pd_v;
  logic [3:0]  m_sh_dp, m_pd_dp;
  bit          m_pv;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz),
`ifdef SEG7_BRIGHTNESS_EN
    .bright(bright),
`endif
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0; m_sh_v = '0; m_sh_dp = '0; m_pd_v = '0; m_pd_dp = '0; m_pv = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
  endtask

  // One clock: predict registered outputs from pre-edge model state, then advance model.
  task automatic step();
    int d;
    logic [3:0] nib;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    bit         fd;
    #1;
    fd = en && ((pos % FRAME) == FRAME - 1);
    chk("frame_done", 32'(frame_done), 32'(fd));
    d = (pos / SCAN_DIV) % DIGITS;
    nib = 4'((m_sh_v >> (4 * d)) & 16'hF);
    if (en) begin
      e_an  = ~(4'b0001 << d);
      e_seg = (blank_lz && d != 0 && (m_sh_v >> (4 * d)) == 0) ? 7'h00 : SEGTBL[nib];
      e_dp  = m_sh_dp[d];
    end else begin
      e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
    end
    @(posedge clk);
    if (en) begin
      if (fd && m_pv) begin m_sh_v = m_pd_v; m_sh_dp = m_pd_dp; end
      if (load) begin m_pd_v = value; m_pd_dp = dp_in; m_pv = 1; end
      else if (fd) m_pv = 0;
      pos++;
    end else if (load) begin
      m_sh_v = value; m_sh_dp = dp_in; m_pv = 0;
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("digit_idx", 32'(digit_idx), 32'((pos / SCAN_DIV) % DIGITS));
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk) rst_n = 1'b1;

    // Scan of 12AF, loaded while disabled.
    load_once(16'h12AF, 4'b0000);
    en = 1'b1;
    repeat (20) step();

    // Mid-frame load must not tear the current frame.
    repeat (6) step();
    load_once(16'h8888, 4'b0000);
    repeat (24) step();

    // Load coincident with frame_done while another update is pending.
    load_once(16'h3456, 4'b0001);
    guard = 0;
    while (((pos % FRAME) != FRAME - 1) && guard < 64) begin step(); guard++; end
    chk("align_frame_end", 32'(pos % FRAME), 32'(FRAME - 1));
    load_once(16'hC0DE, 4'b1010);
    repeat (36) step();

    // Leading-zero blanking and decimal points.
    blank_lz = 1'b1; en = 1'b0;
    load_once(16'h0050, 4'b0000);
    en = 1'b1;
    repeat (16) step();
    en = 1'b0;
    load_once(16'h0000, 4'b0100);
    en = 1'b1;
    repeat (16) step();

    // Enable dropped mid-slot.
    repeat (2) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (8) step();

    // Asynchronous reset mid-slot.
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) step();

    // Random traffic.
    repeat (3000) begin
      en       = ($urandom % 8) != 0;
      load     = ($urandom % 10) == 0;
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      if (($urandom % 3) == 0) value = value & 16'h00FF;
      step();
    end
    load = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
